// File: rtl/packer_pkg.sv
// Shared definitions for the byte packer.
// Holds the default geometry (byte width, lanes per word, word width), the
// FILL/FULL state encoding and a helper that sizes the lane index.
package packer_pkg;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_LANES  = 4;
  localparam int WORD_W     = DEF_BYTE_W * DEF_LANES;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // A single-lane packer still needs a one-bit index to keep vectors legal.
  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/lane_decoder.sv
// Lane write-enable decoder for the byte packer.
// Converts the logical lane index (the order in which bytes arrive) into a
// one-hot write enable over the physical byte positions of the word,
// applying the byte order selected by LITTLE_END.
// Ports:
//   idx      in   IDX_W  logical lane index of the incoming byte
//   en       in   1      input transfer happening this cycle
//   lane_we  out  LANES  one-hot write enable per physical byte position
module lane_decoder
  import packer_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int IDX_W      = 2,
  parameter bit LITTLE_END = 1'b1
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [LANES-1:0] lane_we
);

  // Logical lane g lands in byte g (little endian) or in the mirrored byte.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int POS = LITTLE_END ? g : (LANES - 1 - g);
    assign lane_we[POS] = en && (idx == IDX_W'(g));
  end

endmodule

// File: rtl/byte_packer.sv
// Byte-stream to word packer.
// Accepts one byte per input transfer and collects LANES bytes into a word.
// A word closes when its last lane is written or when the byte carries
// in_last; lanes never written stay zero because the word register is
// cleared whenever a word opens. While a complete word waits downstream,
// in_ready follows out_ready so a new word can start in the same cycle the
// old one leaves.
// Ports:
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous active-low reset
//   in_valid   in   1             in_data/in_last valid
//   in_ready   out  1             packer accepts a byte this cycle
//   in_data    in   BYTE_W        input byte
//   in_last    in   1             final byte of a packet, closes the word
//   out_valid  out  1             complete word presented
//   out_ready  in   1             downstream takes the word this cycle
//   out_data   out  BYTE_W*LANES  packed word
//   out_count  out  clog2(LANES)+1 number of valid bytes, 1..LANES
//   out_last   out  1             word holds the final byte of a packet
module byte_packer
  import packer_pkg::*;
#(
  parameter int BYTE_W     = DEF_BYTE_W,
  parameter int LANES      = DEF_LANES,
  parameter bit LITTLE_END = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTE_W*LANES-1:0]   out_data,
  output logic [$clog2(LANES):0]    out_count,
  output logic                      out_last
);

  localparam int DATA_W = BYTE_W * LANES;
  localparam int IDX_W  = idx_width(LANES);
  localparam int CNT_W  = $clog2(LANES) + 1;

  state_t              state_r;
  state_t              state_s;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    idx_s;
  logic [DATA_W-1:0]   data_r;
  logic [DATA_W-1:0]   data_s;
  logic [CNT_W-1:0]    count_r;
  logic [CNT_W-1:0]    count_s;
  logic                last_r;
  logic                last_s;

  logic                in_xfer_s;
  logic                out_xfer_s;
  logic                open_fresh_s;
  logic                close_s;
  logic [IDX_W-1:0]    wr_idx_s;
  logic [LANES-1:0]    lane_we_s;
  logic [DATA_W-1:0]   base_s;
  logic [DATA_W-1:0]   merged_s;

  // Input handshake: always open while filling, pass-through while full, shut in reset.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      FILL:    in_ready = rst_n;
      FULL:    in_ready = rst_n & out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid & out_ready;

  // A byte accepted while full always starts a fresh word at lane 0.
  assign open_fresh_s = (state_r == FULL) & out_xfer_s;
  assign wr_idx_s     = (state_r == FULL) ? '0 : idx_r;
  assign base_s       = open_fresh_s ? '0 : data_r;
  assign close_s      = in_xfer_s & ((wr_idx_s == IDX_W'(LANES - 1)) | in_last);

  lane_decoder #(
    .LANES      (LANES),
    .IDX_W      (IDX_W),
    .LITTLE_END (LITTLE_END)
  ) u_lane_decoder (
    .idx     (wr_idx_s),
    .en      (in_xfer_s),
    .lane_we (lane_we_s)
  );

  // Word image after writing the accepted byte into its decoded lane.
  always_comb begin
    merged_s = base_s;
    for (int i = 0; i < LANES; i++) begin
      merged_s[i*BYTE_W +: BYTE_W] = lane_we_s[i] ? in_data : base_s[i*BYTE_W +: BYTE_W];
    end
  end

  // Next-state logic for the FSM, lane index and word/count/last registers.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    data_s  = data_r;
    count_s = count_r;
    last_s  = last_r;
    case (state_r)
      FILL: begin
        if (in_xfer_s) begin
          data_s = merged_s;
          if (close_s) begin
            state_s = FULL;
            idx_s   = '0;
            count_s = CNT_W'(wr_idx_s) + CNT_W'(1);
            last_s  = in_last;
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else begin
          data_s = data_r;
        end
      end
      FULL: begin
        if (out_xfer_s) begin
          if (in_xfer_s) begin
            data_s = merged_s;
            if (close_s) begin
              state_s = FULL;
              idx_s   = '0;
              count_s = CNT_W'(1);
              last_s  = in_last;
            end else begin
              state_s = FILL;
              idx_s   = IDX_W'(1);
            end
          end else begin
            state_s = FILL;
            idx_s   = '0;
            data_s  = '0;
          end
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = FILL;
        idx_s   = '0;
        data_s  = '0;
        count_s = '0;
        last_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any word in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
      idx_r   <= '0;
      data_r  <= '0;
      count_r <= '0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      data_r  <= data_s;
      count_r <= count_s;
      last_r  <= last_s;
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = data_r;
  assign out_count = count_r;
  assign out_last  = last_r;

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: a little-endian and a big-endian
// instance share one input stream; a queue-based packet model predicts the
// words each should emit.
module tb_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_le, out_valid_le, out_last_le;
  logic [31:0] out_data_le;
  logic [2:0]  out_count_le;
  logic        in_ready_be, out_valid_be, out_last_be;
  logic [31:0] out_data_be;
  logic [2:0]  out_count_be;

  int checks = 0;
  int fails  = 0;
  int stall  = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  c;
    logic        l;
  } word_t;

  word_t      exp_le[$];
  word_t      exp_be[$];
  word_t      obs_le[$];
  word_t      obs_be[$];
  logic [7:0] part[$];

  always #5 clk = ~clk;

  byte_packer #(.BYTE_W(8), .LANES(4), .LITTLE_END(1'b1)) dut_le (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_le),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_le),
    .out_ready(out_ready), .out_data(out_data_le), .out_count(out_count_le),
    .out_last(out_last_le)
  );

  byte_packer #(.BYTE_W(8), .LANES(4), .LITTLE_END(1'b0)) dut_be (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_be),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_be),
    .out_ready(out_ready), .out_data(out_data_be), .out_count(out_count_be),
    .out_last(out_last_be)
  );

  // Reference model: bytes of the open word kept as a list; a word is formed
  // once four bytes are collected or the packet ends.
  always @(negedge clk) begin
    if (!rst_n) begin
      part.delete();
    end else begin
      if (out_valid_le && out_ready) obs_le.push_back({out_data_le, out_count_le, out_last_le});
      if (out_valid_be && out_ready) obs_be.push_back({out_data_be, out_count_be, out_last_be});
      if (in_valid && in_ready_le) begin
        part.push_back(in_data);
        if (part.size() == 4 || in_last) begin
          word_t wl;
          word_t wb;
          wl = '0;
          wb = '0;
          for (int i = 0; i < part.size(); i++) begin
            wl.d = wl.d | (32'(part[i]) << (8 * i));
            wb.d = wb.d | (32'(part[i]) << (8 * (3 - i)));
          end
          wl.c = 3'(part.size());
          wb.c = 3'(part.size());
          wl.l = in_last;
          wb.l = in_last;
          exp_le.push_back(wl);
          exp_be.push_back(wb);
          part.delete();
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    @(negedge clk);
    while (!in_ready_le && n < 200) begin
      n++;
      @(negedge clk);
    end
    stall += n;
    checks++;
    if (n >= 200) begin
      fails++;
      $display("FAIL send_timeout: byte %h not accepted within %0d cycles (required within 200)", b, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    #3;
    checks++; if (out_valid_le !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid_le); end
    checks++; if (out_data_le !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", out_data_le); end
    checks++; if (out_count_le !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", out_count_le); end
    checks++; if (out_last_le !== 1'b0) begin fails++; $display("FAIL reset_last: got %b want 0", out_last_le); end
    checks++; if (in_ready_le !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready_le); end
    checks++; if (in_ready_be !== 1'b0) begin fails++; $display("FAIL reset_in_ready_be: got %b want 0", in_ready_be); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_le !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready_le); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    checks++; if (out_valid_le !== 1'b0) begin fails++; $display("FAIL full_early_valid: got %b want 0", out_valid_le); end
    send_byte(8'h44, 1'b1);
    checks++; if (out_valid_le !== 1'b1) begin fails++; $display("FAIL full_valid: got %b want 1", out_valid_le); end
    checks++; if (out_data_le !== 32'h44332211) begin fails++; $display("FAIL full_data: got %h want 44332211", out_data_le); end
    checks++; if (out_count_le !== 3'd4) begin fails++; $display("FAIL full_count: got %0d want 4", out_count_le); end
    checks++; if (out_last_le !== 1'b1) begin fails++; $display("FAIL full_last: got %b want 1", out_last_le); end
    @(posedge clk);
    #1;
    checks++; if (out_valid_le !== 1'b0) begin fails++; $display("FAIL full_taken: got valid %b want 0", out_valid_le); end
  endtask

  task automatic test_early_close();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    checks++; if (out_data_le !== 32'h00CCBBAA) begin fails++; $display("FAIL early_data: got %h want 00ccbbaa", out_data_le); end
    checks++; if (out_count_le !== 3'd3) begin fails++; $display("FAIL early_count: got %0d want 3", out_count_le); end
    checks++; if (out_last_le !== 1'b1) begin fails++; $display("FAIL early_last: got %b want 1", out_last_le); end
    checks++; if (out_data_be !== 32'hAABBCC00) begin fails++; $display("FAIL early_data_be: got %h want aabbcc00", out_data_be); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (in_ready_le !== 1'b0) begin fails++; $display("FAIL hold_in_ready[%0d]: got %b want 0", k, in_ready_le); end
      checks++; if (out_valid_le !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d]: got %b want 1", k, out_valid_le); end
      checks++; if (out_data_le !== 32'h04030201) begin fails++; $display("FAIL hold_data[%0d]: got %h want 04030201", k, out_data_le); end
      checks++; if (out_count_le !== 3'd4 || out_last_le !== 1'b0) begin fails++; $display("FAIL hold_count_last[%0d]: got %0d/%b want 4/0", k, out_count_le, out_last_le); end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_le !== 1'b1) begin fails++; $display("FAIL passthru_in_ready: got %b want 1", in_ready_le); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (out_valid_le !== 1'b1) begin fails++; $display("FAIL fresh_valid: got %b want 1", out_valid_le); end
    checks++; if (out_data_le !== 32'h0000005A) begin fails++; $display("FAIL fresh_data: got %h want 0000005a", out_data_le); end
    checks++; if (out_count_le !== 3'd1 || out_last_le !== 1'b1) begin fails++; $display("FAIL fresh_count_last: got %0d/%b want 1/1", out_count_le, out_last_le); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    obs_le.delete();
    stall = 0;
    for (int k = 1; k <= 8; k++) send_byte(8'(k), 1'b0);
    @(negedge clk);
    #1;
    checks++; if (stall !== 0) begin fails++; $display("FAIL b2b_stall: got %0d stall cycles want 0", stall); end
    checks++;
    if (obs_le.size() != 2) begin
      fails++; $display("FAIL b2b_words: got %0d words want 2", obs_le.size());
    end else begin
      checks++; if (obs_le[0] !== {32'h04030201, 3'd4, 1'b0}) begin fails++; $display("FAIL b2b_word0: got %h want %h", obs_le[0], {32'h04030201, 3'd4, 1'b0}); end
      checks++; if (obs_le[1] !== {32'h08070605, 3'd4, 1'b0}) begin fails++; $display("FAIL b2b_word1: got %h want %h", obs_le[1], {32'h08070605, 3'd4, 1'b0}); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_big_endian();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    checks++; if (out_data_be !== 32'h11220000) begin fails++; $display("FAIL be_data: got %h want 11220000", out_data_be); end
    checks++; if (out_count_be !== 3'd2 || out_last_be !== 1'b1) begin fails++; $display("FAIL be_count_last: got %0d/%b want 2/1", out_count_be, out_last_be); end
    checks++; if (out_data_le !== 32'h00002211) begin fails++; $display("FAIL le_pair_data: got %h want 00002211", out_data_le); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_data_le !== 32'h0 || out_valid_le !== 1'b0) begin fails++; $display("FAIL arst_out: got %h/%b want 0/0", out_data_le, out_valid_le); end
    checks++; if (in_ready_le !== 1'b0 || out_count_le !== 3'd0) begin fails++; $display("FAIL arst_ready_count: got %b/%0d want 0/0", in_ready_le, out_count_le); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    checks++; if (out_data_le !== 32'hA4A3A2A1 || out_count_le !== 3'd4 || out_last_le !== 1'b0) begin fails++; $display("FAIL arst_word: got %h/%0d/%b want a4a3a2a1/4/0", out_data_le, out_count_le, out_last_le); end
    checks++; if (out_data_be !== 32'hA1A2A3A4) begin fails++; $display("FAIL arst_word_be: got %h want a1a2a3a4", out_data_be); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_le.delete(); exp_be.delete(); obs_le.delete(); obs_be.delete();
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send_byte(8'($urandom), 1'($urandom_range(0, 4) == 0));
        end
        send_byte(8'($urandom), 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obs_le.size() != exp_le.size() || exp_le.size() == 0) begin fails++; $display("FAIL rand_count_le: got %0d words want %0d", obs_le.size(), exp_le.size()); end
    checks++; if (obs_be.size() != exp_be.size()) begin fails++; $display("FAIL rand_count_be: got %0d words want %0d", obs_be.size(), exp_be.size()); end
    for (int i = 0; i < obs_le.size() && i < exp_le.size(); i++) begin
      checks++; if (obs_le[i] !== exp_le[i]) begin fails++; $display("FAIL rand_le[%0d]: got %h/%0d/%b want %h/%0d/%b", i, obs_le[i].d, obs_le[i].c, obs_le[i].l, exp_le[i].d, exp_le[i].c, exp_le[i].l); end
    end
    for (int i = 0; i < obs_be.size() && i < exp_be.size(); i++) begin
      checks++; if (obs_be[i] !== exp_be[i]) begin fails++; $display("FAIL rand_be[%0d]: got %h/%0d/%b want %h/%0d/%b", i, obs_be[i].d, obs_be[i].c, obs_be[i].l, exp_be[i].d, exp_be[i].c, exp_be[i].l); end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_early_close();
    test_backpressure();
    test_back_to_back();
    test_big_endian();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
